ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the MIPS datapath; successor to the fixed 5-bit zero extender.
- Takes an IN_W-bit field (immediate or shamt) and a mode, and produces an OUT_W-bit operand: zero-extended, sign-extended, LUI-style high-placed, or branch-offset (sign-extend plus left shift).
- Sits between decode and execute, behind a valid/ready handshake, with a 2-entry skid buffer so execute stalls never drop or duplicate operands.

Parameters:
- IN_W, 16, input field width; legal range 1..OUT_W-1.
- OUT_W, 32, output operand width.
- BR_SHIFT, 2, left shift applied in branch mode; legal range 0..OUT_W-1.
- TAG_W, 5, width of the sideband tag carried alongside the data (e.g. destination register number).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream holds a valid operand.
- in_ready  output  1  block can accept this cycle.
- in_data  input  IN_W  raw field.
- in_mode  input  2  00 zero, 01 sign, 10 high, 11 branch.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  out_data/out_tag are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  OUT_W  extended operand.
- out_tag  output  TAG_W  tag matching out_data.

Behaviour:
Extension (combinational on input, registered into the pipeline):
- zero: {0, in_data}.
- sign: replicate in_data[IN_W-1] into the upper OUT_W-IN_W bits.
- high: in_data placed in bits [OUT_W-1 : OUT_W-IN_W]; lower bits 0.
- branch: sign-extend, then shift left by BR_SHIFT; bits shifted past OUT_W-1 are discarded.

Storage:
- Two entries: main (drives outputs) and skid.
- Each entry holds valid, data and tag.

Handshake:
- in_ready = !skid_valid. It is registered state, with no combinational path from out_ready.
- Input fire = in_valid && in_ready.
- Output fire = out_valid && out_ready.
- out_valid = main_valid. out_data and out_tag are stable while out_valid=1 and out_ready=0.
- Latency: one cycle from input fire to out_valid when main is empty or firing.
- Throughput: one per cycle when out_ready=1.

Next-state rules, per cycle:
- main empty or output fire, skid empty: an input fire loads main; otherwise main_valid <= 0 if output fired.
- main full, no output fire, input fire: the new entry goes to skid. in_ready drops the next cycle.
- output fire with skid full: main <= skid and skid clears. A simultaneous input fire is impossible because in_ready=0.
- main full, no output fire, no input fire: hold.
- Ordering is strictly FIFO; no entry is dropped or duplicated.

Reset:
- rst_n low asynchronously clears main_valid and skid_valid, and sets out_data=0 and out_tag=0.
- Result: out_valid=0 and in_ready=1.
- Reset mid-stall discards both entries; no stale entry appears after release.

Boundary conditions:
- IN_W=5, mode 00 reproduces the old shamt zero-extend.
- Branch with BR_SHIFT=0 equals sign mode.
- in_data/in_mode/in_tag are ignored when in_valid=0.

Decomposition:
- Shared package ext_pkg: mode constants EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_HIGH=2'b10, EXT_BRANCH=2'b11, plus a 2-bit ext_mode_t typedef. Decode also imports this package.
- One natural sub-module: ext_core, a pure combinational extender parametrised on IN_W/OUT_W/BR_SHIFT.
- The top-level ext_pipe holds the skid-buffer control and storage.

Test Plan:
1. Zero mode, defaults: in_data=16'h8001 -> out_data=32'h0000_8001 with out_valid one cycle after fire; in_tag=5'd7 -> out_tag=5'd7.
2. Sign mode: 16'h8001 -> 32'hFFFF_8001; 16'h7FFF -> 32'h0000_7FFF, issued back-to-back on consecutive cycles with out_ready=1 -> one result per cycle.
3. High and branch modes: high 16'h1234 -> 32'h1234_0000. Branch 16'hFFFF -> 32'hFFFF_FFFC; 16'h0001 -> 32'h0000_0004; 16'h8000 -> 32'hFFFE_0000.
4. Backpressure: out_ready=0, stream A,B,C -> A in main, B in skid, in_ready=0 the cycle after B, C held upstream. Raise out_ready -> A,B,C emerge in order on consecutive cycles, no loss or duplication, and out_data is stable while stalled.
5. Reset mid-operation: both entries full, pulse rst_n low between clock edges -> out_valid=0, in_ready=1 and out_data=0 immediately. After release, out_valid stays 0 until a new input fires.
6. Parameter sweep: IN_W=5, OUT_W=32, mode 00, in_data=5'h1F -> 32'h0000_001F; mode 01 -> 32'hFFFF_FFFF.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared immediate-extension mode encoding, imported by decode and the extender.
package ext_pkg;

   typedef logic [1:0] ext_mode_t;

   localparam ext_mode_t EXT_ZERO   = 2'b00;
   localparam ext_mode_t EXT_SIGN   = 2'b01;
   localparam ext_mode_t EXT_HIGH   = 2'b10;
   localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/ext_core.sv
// Pure combinational immediate extender: zero, sign, high-placed or branch offset.
module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] ext_data
);

   logic signed [OUT_W-1:0] sext;

   always_comb begin
      sext     = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
      ext_data = '0;
      case (ext_mode_t'(mode))
         EXT_ZERO:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
         EXT_SIGN:   ext_data = sext;
         EXT_HIGH:   ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
         // Bits shifted past the MSB simply fall off the fixed-width result.
         EXT_BRANCH: ext_data = sext <<< BR_SHIFT;
         default:    ext_data = '0;
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender behind a valid/ready handshake with a 2-entry skid buffer.
module ext_pipe
   import ext_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   logic [OUT_W-1:0] ext_data_p0;

   logic             main_valid;
   logic [OUT_W-1:0] main_data;
   logic [TAG_W-1:0] main_tag;
   logic             skid_valid;
   logic [OUT_W-1:0] skid_data;
   logic [TAG_W-1:0] skid_tag;

   logic in_fire;
   logic out_fire;

   ext_core #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .BR_SHIFT(BR_SHIFT)
   ) u_core (
      .in_data (in_data),
      .mode    (in_mode),
      .ext_data(ext_data_p0)
   );

   // in_ready depends only on registered state, never on out_ready.
   assign in_ready  = !skid_valid;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid && out_ready;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_tag   = main_tag;

   // Stage boundary: extended operand registered into main/skid entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_tag   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_tag   <= '0;
      end else if (skid_valid) begin
         if (out_fire) begin
            main_data  <= skid_data;
            main_tag   <= skid_tag;
            skid_valid <= 1'b0;
         end
      end else if (!main_valid || out_fire) begin
         main_valid <= in_fire;
         if (in_fire) begin
            main_data <= ext_data_p0;
            main_tag  <= in_tag;
         end
      end else if (in_fire) begin
         skid_valid <= 1'b1;
         skid_data  <= ext_data_p0;
         skid_tag   <= in_tag;
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: extension modes, skid backpressure, async reset, narrow-field instance.
module tb_ext_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   logic        d5_in_valid;
   logic        d5_in_ready;
   logic [4:0]  d5_in_data;
   logic [1:0]  d5_in_mode;
   logic [4:0]  d5_in_tag;
   logic        d5_out_valid;
   logic        d5_out_ready;
   logic [31:0] d5_out_data;
   logic [4:0]  d5_out_tag;

   int total;
   int passed;

   ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   ext_pipe #(.IN_W(5), .OUT_W(32), .BR_SHIFT(0), .TAG_W(5)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d5_in_valid), .in_ready(d5_in_ready), .in_data(d5_in_data),
      .in_mode(d5_in_mode), .in_tag(d5_in_tag),
      .out_valid(d5_out_valid), .out_ready(d5_out_ready),
      .out_data(d5_out_data), .out_tag(d5_out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d, input logic [4:0] t);
      in_valid = v;
      in_mode  = m;
      in_data  = d;
      in_tag   = t;
   endtask

   // Single transfer with out_ready=1: result appears one cycle after fire.
   task automatic xfer(input string tag, input logic [1:0] m, input logic [15:0] d, input logic [31:0] exp);
      drive(1'b1, m, d, 5'd3);
      step();
      drive(1'b0, 2'b00, 16'h0000, 5'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check(tag, out_data, exp);
      step();
   endtask

   initial begin
      total = 0;
      passed = 0;
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 16'h0000, 5'd0);
      out_ready = 1'b1;
      d5_in_valid = 1'b0; d5_in_data = 5'd0; d5_in_mode = 2'b00; d5_in_tag = 5'd0;
      d5_out_ready = 1'b1;

      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_data", out_data, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Zero mode, one-cycle latency, tag pass-through
      drive(1'b1, 2'b00, 16'h8001, 5'd7);
      check("zero_pre_valid", 32'(out_valid), 32'd0);
      step();
      drive(1'b0, 2'b00, 16'h0000, 5'd0);
      check("zero_valid", 32'(out_valid), 32'd1);
      check("zero_data", out_data, 32'h0000_8001);
      check("zero_tag", 32'(out_tag), 32'd7);
      step();
      check("zero_drained", 32'(out_valid), 32'd0);

      // Sign mode back-to-back
      drive(1'b1, 2'b01, 16'h8001, 5'd1);
      step();
      drive(1'b1, 2'b01, 16'h7FFF, 5'd2);
      check("sign_neg", out_data, 32'hFFFF_8001);
      check("sign_neg_tag", 32'(out_tag), 32'd1);
      step();
      drive(1'b0, 2'b00, 16'h0000, 5'd0);
      check("sign_pos_valid", 32'(out_valid), 32'd1);
      check("sign_pos", out_data, 32'h0000_7FFF);
      check("sign_pos_tag", 32'(out_tag), 32'd2);
      step();
      check("sign_drained", 32'(out_valid), 32'd0);

      // High and branch modes
      xfer("high", 2'b10, 16'h1234, 32'h1234_0000);
      xfer("br_m1", 2'b11, 16'hFFFF, 32'hFFFF_FFFC);
      xfer("br_p1", 2'b11, 16'h0001, 32'h0000_0004);
      xfer("br_min", 2'b11, 16'h8000, 32'hFFFE_0000);

      // Inputs ignored while in_valid=0
      drive(1'b0, 2'b01, 16'hDEAD, 5'd9);
      step();
      check("idle_ignored", 32'(out_valid), 32'd0);

      // Backpressure: A in main, B in skid, C held upstream
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 16'h0011, 5'd1);
      step();
      drive(1'b1, 2'b01, 16'h8000, 5'd2);
      check("bp_a_main", out_data, 32'h0000_0011);
      check("bp_ready_b", 32'(in_ready), 32'd1);
      step();
      drive(1'b1, 2'b10, 16'h00AB, 5'd3);
      check("bp_ready_drop", 32'(in_ready), 32'd0);
      check("bp_a_stable1", out_data, 32'h0000_0011);
      step();
      check("bp_ready_held", 32'(in_ready), 32'd0);
      check("bp_a_stable2", out_data, 32'h0000_0011);
      check("bp_a_tag", 32'(out_tag), 32'd1);
      out_ready = 1'b1;
      step();
      check("bp_b_out", out_data, 32'hFFFF_8000);
      check("bp_b_tag", 32'(out_tag), 32'd2);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      step();
      drive(1'b0, 2'b00, 16'h0000, 5'd0);
      check("bp_c_valid", 32'(out_valid), 32'd1);
      check("bp_c_out", out_data, 32'h00AB_0000);
      check("bp_c_tag", 32'(out_tag), 32'd3);
      step();
      check("bp_no_dup", 32'(out_valid), 32'd0);

      // Reset with both entries full
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 16'h0055, 5'd4);
      step();
      drive(1'b1, 2'b00, 16'h0066, 5'd5);
      step();
      drive(1'b0, 2'b00, 16'h0000, 5'd0);
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_data", out_data, 32'h0);
      check("mid_rst_tag", 32'(out_tag), 32'd0);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      check("post_rst_empty", 32'(out_valid), 32'd0);
      xfer("post_rst_new", 2'b01, 16'hFFF0, 32'hFFFF_FFF0);

      // Narrow field instance (IN_W=5, BR_SHIFT=0)
      d5_in_valid = 1'b1; d5_in_mode = 2'b00; d5_in_data = 5'h1F; d5_in_tag = 5'd6;
      step();
      d5_in_mode = 2'b01;
      check("w5_zero", d5_out_data, 32'h0000_001F);
      check("w5_zero_tag", 32'(d5_out_tag), 32'd6);
      step();
      d5_in_mode = 2'b11; d5_in_data = 5'h10;
      check("w5_sign", d5_out_data, 32'hFFFF_FFFF);
      step();
      d5_in_valid = 1'b0;
      check("w5_br0_eq_sign", d5_out_data, 32'hFFFF_FFF0);
      step();
      check("w5_drained", 32'(d5_out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
